fetch_ctrl: RTL

//  Sequencer for the FETCH stage: owns the program counter and the instruction

---
 rtl/fetch_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - FETCH-stage PC sequencer with loader write port and debug halt
// Optional feature macro: FETCH_PERF_EN (RUN-cycle / stall / redirect counters).
`ifndef WORD
`define WORD 32
`endif

module fetch_ctrl #(
  parameter int                IMEM_POWER = 18,
  parameter logic [`WORD-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [IMEM_POWER-1:0] load_addr,
  input  logic [`WORD-1:0]      load_data,
  input  logic                  load_done,
  output logic                  load_ready,
  output logic                  imem_we,
  output logic [IMEM_POWER-1:0] imem_waddr,
  output logic [`WORD-1:0]      imem_wdata,
  input  logic                  stallF,
  input  logic                  redirect_valid,
  input  logic [`WORD-1:0]      redirect_pc,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [`WORD-1:0]      pcF,
  output logic                  pc_oob,
  output logic                  fetchreg_en,
  output logic                  fetchreg_flush,
  output logic [1:0]            state,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stalls,
  output logic [31:0]           perf_redirects
);

  localparam logic [1:0] S_BOOT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;
  localparam logic [`WORD-1:0] ALIGN_MASK = {{(`WORD-2){1'b1}}, 2'b00};

  logic [1:0]       state_q, state_d;
  logic [`WORD-1:0] pc_q, pc_d;
  logic             in_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (halt_req) state_d = S_HALT;
      S_HALT:  if (resume && !halt_req) state_d = S_RUN;
      default: state_d = load_done ? S_RUN : S_BOOT;  // 2'b11 treated as BOOT
    endcase
  end

  always_comb begin
    load_ready     = 1'b0;
    fetchreg_en    = 1'b1;
    fetchreg_flush = 1'b1;
    pc_d           = pc_q;
    in_run         = 1'b0;
    case (state_q)
      S_RUN: begin
        in_run = 1'b1;
        if (redirect_valid) begin
          pc_d = redirect_pc & ALIGN_MASK;
        end else if (stallF) begin
          fetchreg_en    = 1'b0;
          fetchreg_flush = 1'b0;
        end else begin
          pc_d           = pc_q + `WORD'd4;
          fetchreg_flush = pc_oob;
        end
      end
      S_HALT: ;
      default: begin
        load_ready  = 1'b1;
        fetchreg_en = 1'b0;
      end
    endcase
  end

  assign imem_we    = load_valid & load_ready;
  assign imem_waddr = load_addr;
  assign imem_wdata = load_data;
  assign pcF        = pc_q;
  assign pc_oob     = |pc_q[`WORD-1:IMEM_POWER+2];
  assign state      = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] cyc_q, stall_q, redir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q   <= '0;
      stall_q <= '0;
      redir_q <= '0;
    end else if (in_run) begin
      cyc_q <= cyc_q + 32'd1;
      if (redirect_valid)  redir_q <= redir_q + 32'd1;
      else if (stallF)     stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_cycles    = cyc_q;
  assign perf_stalls    = stall_q;
  assign perf_redirects = redir_q;
`else
  assign perf_cycles    = '0;
  assign perf_stalls    = '0;
  assign perf_redirects = '0;
`endif

endmodule
